ysyx_22051013_pipe_ctrl: RTL and testbench
==========================================

Name: ysyx_22051013_pipe_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, LS, WB).
- Drives the hold and bubble controls of the pc, if/id, id/ex, ex/ls and ls/wb pipeline registers.
- Resolves load-use hazards, multi-cycle LSU and IFU waits, and EX-stage redirects.
- Pipeline registers obey its controls; it owns no datapath.

Parameters:
- REGADDR_W, 5, register-address width.
- MEM_TIMEOUT, 255, LSU wait cycles before aborting with mem_err (8-bit counter, 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_rs1_addr  in  REGADDR_W  ID source 1
- id_rs1_ren  in  1  ID reads rs1
- id_rs2_addr  in  REGADDR_W  ID source 2
- id_rs2_ren  in  1  ID reads rs2
- ex_rd_addr  in  REGADDR_W  EX destination
- ex_rd_ena  in  1  EX writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_redirect  in  1  EX branch taken / jump / trap target valid
- if_req  in  1  IFU fetch outstanding
- if_ack  in  1  IFU fetch data valid
- ls_req  in  1  LSU access outstanding
- ls_ack  in  1  LSU access complete
- pc_hold  out  1  pc keeps value
- ifid_hold  out  1  if/id register holds
- ifid_flush  out  1  if/id register loads bubble
- idex_hold  out  1  id/ex register holds
- idex_flush  out  1  id/ex register loads bubble
- exls_hold  out  1  ex/ls register holds
- lswb_flush  out  1  ls/wb register loads bubble
- redirect_take  out  1  pc loads redirect target this cycle
- mem_err  out  1  one-cycle pulse on LSU timeout

Behaviour:
- FSM states: RUN, LU_BUBBLE, MEM_WAIT, REDIR_PEND.
- Reset (rst=0): state RUN, counter 0, redir_pending 0, all outputs 0. Applies asynchronously, including mid-MEM_WAIT.
- Outputs are combinational from state and inputs. Per-cycle priority, highest first:
  1. MEM_WAIT
  2. redirect
  3. load-use
  4. fetch wait
- Load-use hit: ex_is_load & ex_rd_ena & ex_rd_addr!=0 & ((id_rs1_ren & id_rs1_addr==ex_rd_addr) | (id_rs2_ren & id_rs2_addr==ex_rd_addr)).
- Load-use in RUN:
  - Same cycle: pc_hold=1, ifid_hold=1, idex_flush=1.
  - Next state LU_BUBBLE for exactly 1 cycle, with no re-detection there.
  - Back to RUN; the LS-stage forward covers the dependency.
- LSU wait: ls_req & !ls_ack in RUN or LU_BUBBLE:
  - pc_hold, ifid_hold, idex_hold, exls_hold, lswb_flush all 1.
  - Enter MEM_WAIT; counter starts at 1.
- MEM_WAIT:
  - All holds stay 1; counter +1 per cycle.
  - ls_ack=1: holds drop in that same cycle, next state RUN (or REDIR_PEND if redir_pending).
  - Counter==MEM_TIMEOUT without ack: mem_err=1 for 1 cycle, holds drop, next state RUN. The counter saturates and never wraps.
- Redirect:
  - ex_redirect in RUN/LU_BUBBLE: ifid_flush=1, idex_flush=1, redirect_take=1; all holds 0. This overrides load-use in the same cycle.
  - ex_redirect during MEM_WAIT: set redir_pending, no flush yet.
  - On MEM_WAIT exit: go to REDIR_PEND. That state drives ifid_flush, idex_flush and redirect_take for 1 cycle, then RUN and redir_pending clears.
- Fetch wait: if_req & !if_ack with no higher event gives pc_hold=1 and ifid_flush=1; ID and later stages continue to drain.
- Simultaneous redirect + fetch wait: redirect_take wins; the IFU drops the stale fetch.
- ls_ack in the same cycle as ls_req: no stall and no MEM_WAIT entry.

Optional Feature:
- Macro: YSYX_22051013_PIPE_PERF_EN.
- Defined: three 32-bit counters, read-only output ports.
  - perf_lu_cnt: load-use bubbles.
  - perf_mem_cnt: MEM_WAIT cycles.
  - perf_flush_cnt: redirect flushes.
  - Counters wrap at 2^32, are cleared by rst, and count only cycles with the corresponding output asserted.
- Undefined: the counters and their ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared define file holds:
  - state encodings ysyx_22051013_PCTL_RUN/LU/MEMW/REDIR (2-bit)
  - REGADDR width macro
  - MEM_TIMEOUT default
- One natural sub-module: ysyx_22051013_hazard_det, the combinational load-use comparator.
- The FSM, counter and output decode stay in the top module.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5 ren=1 → cycle 0 pc_hold=ifid_hold=idex_flush=1; cycle 1 (LU_BUBBLE) all 0; x0 destination → no stall.
- LSU 3-cycle: ls_req=1, ls_ack at cycle 3 → holds=1 and lswb_flush=1 on cycles 0-2, all 0 on cycle 3, state RUN.
- Timeout with MEM_TIMEOUT=4, ack never → mem_err pulse on cycle 3, holds drop same cycle, RUN next.
- Redirect inside MEM_WAIT, ack at cycle 2 → no flush on cycles 0-2; cycle 3 ifid_flush=idex_flush=redirect_take=1; cycle 4 RUN.
- Redirect + load-use same cycle → redirect_take=1, idex_flush=1, ifid_hold=0, state stays RUN.
- rst low during MEM_WAIT → outputs 0 immediately (asynchronous), state RUN after release; with PERF_EN all counters read 0.

Source files
------------

// File: rtl/ysyx_22051013_pipe_ctrl_pkg.sv
// Shared constants, FSM encodings and output-bundle helpers for the pipeline stall/flush scheduler.
package ysyx_22051013_pipe_ctrl_pkg;

  localparam int YSYX_22051013_REGADDR_W   = 5;
  localparam int YSYX_22051013_MEM_TIMEOUT = 255;

  localparam logic [1:0] YSYX_22051013_PCTL_RUN   = 2'd0;
  localparam logic [1:0] YSYX_22051013_PCTL_LU    = 2'd1;
  localparam logic [1:0] YSYX_22051013_PCTL_MEMW  = 2'd2;
  localparam logic [1:0] YSYX_22051013_PCTL_REDIR = 2'd3;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_flush;
    logic exls_hold;
    logic lswb_flush;
    logic redirect_take;
    logic mem_err;
  } pctl_out_t;

  // Freeze everything up to LS and inject a bubble into WB.
  function automatic pctl_out_t f_mem_stall();
    pctl_out_t v;
    v            = '0;
    v.pc_hold    = 1'b1;
    v.ifid_hold  = 1'b1;
    v.idex_hold  = 1'b1;
    v.exls_hold  = 1'b1;
    v.lswb_flush = 1'b1;
    return v;
  endfunction

  function automatic pctl_out_t f_redirect();
    pctl_out_t v;
    v               = '0;
    v.ifid_flush    = 1'b1;
    v.idex_flush    = 1'b1;
    v.redirect_take = 1'b1;
    return v;
  endfunction

  function automatic pctl_out_t f_load_use();
    pctl_out_t v;
    v            = '0;
    v.pc_hold    = 1'b1;
    v.ifid_hold  = 1'b1;
    v.idex_flush = 1'b1;
    return v;
  endfunction

  function automatic pctl_out_t f_fetch_wait();
    pctl_out_t v;
    v            = '0;
    v.pc_hold    = 1'b1;
    v.ifid_flush = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ysyx_22051013_pipe_ctrl_if.sv
// Hazard inputs and stage-register controls exchanged between the pipeline (master) and the scheduler (slave).
interface ysyx_22051013_pipe_ctrl_if #(
  parameter int REGADDR_W = 5
);
  logic [REGADDR_W-1:0] id_rs1_addr;
  logic                 id_rs1_ren;
  logic [REGADDR_W-1:0] id_rs2_addr;
  logic                 id_rs2_ren;
  logic [REGADDR_W-1:0] ex_rd_addr;
  logic                 ex_rd_ena;
  logic                 ex_is_load;
  logic                 ex_redirect;
  logic                 if_req;
  logic                 if_ack;
  logic                 ls_req;
  logic                 ls_ack;

  logic                 pc_hold;
  logic                 ifid_hold;
  logic                 ifid_flush;
  logic                 idex_hold;
  logic                 idex_flush;
  logic                 exls_hold;
  logic                 lswb_flush;
  logic                 redirect_take;
  logic                 mem_err;

  modport master (
    output id_rs1_addr, id_rs1_ren, id_rs2_addr, id_rs2_ren,
    output ex_rd_addr, ex_rd_ena, ex_is_load, ex_redirect,
    output if_req, if_ack, ls_req, ls_ack,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
    input  exls_hold, lswb_flush, redirect_take, mem_err
  );

  modport slave (
    input  id_rs1_addr, id_rs1_ren, id_rs2_addr, id_rs2_ren,
    input  ex_rd_addr, ex_rd_ena, ex_is_load, ex_redirect,
    input  if_req, if_ack, ls_req, ls_ack,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
    output exls_hold, lswb_flush, redirect_take, mem_err
  );
endinterface

// File: rtl/ysyx_22051013_pipe_ctrl_hazard_det.sv
// Combinational load-use comparator: an ID source matches the destination of a load sitting in EX.
module ysyx_22051013_hazard_det #(
  parameter int REGADDR_W = 5
) (
  input  logic [REGADDR_W-1:0] i_rs1_addr,
  input  logic                 i_rs1_ren,
  input  logic [REGADDR_W-1:0] i_rs2_addr,
  input  logic                 i_rs2_ren,
  input  logic [REGADDR_W-1:0] i_rd_addr,
  input  logic                 i_rd_ena,
  input  logic                 i_is_load,
  output logic                 o_lu_hit
);
  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never a real producer, so it can't create a dependency.
  assign w_rd_live = i_is_load & i_rd_ena & (i_rd_addr != {REGADDR_W{1'b0}});
  assign w_rs1_hit = i_rs1_ren & (i_rs1_addr == i_rd_addr);
  assign w_rs2_hit = i_rs2_ren & (i_rs2_addr == i_rd_addr);
  assign o_lu_hit  = w_rd_live & (w_rs1_hit | w_rs2_hit);
endmodule

// File: rtl/ysyx_22051013_pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline; outputs decode combinationally from FSM state and hazards.
// Optional perf counters: define YSYX_22051013_PIPE_PERF_EN.
module ysyx_22051013_pipe_ctrl
  import ysyx_22051013_pipe_ctrl_pkg::*;
#(
  parameter int REGADDR_W   = YSYX_22051013_REGADDR_W,
  parameter int MEM_TIMEOUT = YSYX_22051013_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  ysyx_22051013_pipe_ctrl_if.slave bus
`ifdef YSYX_22051013_PIPE_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_mem_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [8:0] LP_TIMEOUT = 9'(MEM_TIMEOUT);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_pend;
  logic       w_pend_nxt;
  logic       w_pend_any;
  logic       w_lu_hit;
  logic       w_lu_take;
  logic       w_lsu_wait;
  logic       w_fetch_wait;
  logic       w_timeout;
  pctl_out_t  w_dec;
  pctl_out_t  w_out;

  ysyx_22051013_hazard_det #(
    .REGADDR_W (REGADDR_W)
  ) u_hazard_det (
    .i_rs1_addr (bus.id_rs1_addr),
    .i_rs1_ren  (bus.id_rs1_ren),
    .i_rs2_addr (bus.id_rs2_addr),
    .i_rs2_ren  (bus.id_rs2_ren),
    .i_rd_addr  (bus.ex_rd_addr),
    .i_rd_ena   (bus.ex_rd_ena),
    .i_is_load  (bus.ex_is_load),
    .o_lu_hit   (w_lu_hit)
  );

  assign w_lsu_wait   = bus.ls_req & ~bus.ls_ack;
  assign w_fetch_wait = bus.if_req & ~bus.if_ack;
  assign w_pend_any   = r_pend | bus.ex_redirect;
  // r_cnt counts the wait cycles already spent; the current cycle is the +1.
  assign w_timeout    = (({1'b0, r_cnt} + 9'd1) >= LP_TIMEOUT);

  // Next-state and per-cycle control decode.
  always_comb begin
    w_dec       = '0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_lu_take   = 1'b0;
    case (r_state)
      YSYX_22051013_PCTL_MEMW: begin
        if (bus.ls_ack) begin
          w_state_nxt = w_pend_any ? YSYX_22051013_PCTL_REDIR : YSYX_22051013_PCTL_RUN;
          w_cnt_nxt   = 8'd0;
          w_pend_nxt  = w_pend_any;
        end else if (w_timeout) begin
          // A redirect caught during the wait must still be honoured after an abort.
          w_dec.mem_err = 1'b1;
          w_state_nxt   = w_pend_any ? YSYX_22051013_PCTL_REDIR : YSYX_22051013_PCTL_RUN;
          w_cnt_nxt     = 8'd0;
          w_pend_nxt    = w_pend_any;
        end else begin
          w_dec      = f_mem_stall();
          w_cnt_nxt  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
          w_pend_nxt = w_pend_any;
        end
      end
      YSYX_22051013_PCTL_REDIR: begin
        if (w_lsu_wait) begin
          w_dec       = f_mem_stall();
          w_state_nxt = YSYX_22051013_PCTL_MEMW;
          w_cnt_nxt   = 8'd1;
        end else begin
          w_dec       = f_redirect();
          w_state_nxt = YSYX_22051013_PCTL_RUN;
          w_pend_nxt  = 1'b0;
        end
      end
      YSYX_22051013_PCTL_RUN, YSYX_22051013_PCTL_LU: begin
        if (w_lsu_wait) begin
          w_dec       = f_mem_stall();
          w_state_nxt = YSYX_22051013_PCTL_MEMW;
          w_cnt_nxt   = 8'd1;
          w_pend_nxt  = w_pend_any;
        end else if (bus.ex_redirect) begin
          w_dec       = f_redirect();
          w_state_nxt = YSYX_22051013_PCTL_RUN;
        end else if ((r_state == YSYX_22051013_PCTL_RUN) && w_lu_hit) begin
          w_dec       = f_load_use();
          w_lu_take   = 1'b1;
          w_state_nxt = YSYX_22051013_PCTL_LU;
        end else if (w_fetch_wait) begin
          w_dec       = f_fetch_wait();
          w_state_nxt = YSYX_22051013_PCTL_RUN;
        end else begin
          w_state_nxt = YSYX_22051013_PCTL_RUN;
        end
      end
      default: begin
        w_state_nxt = YSYX_22051013_PCTL_RUN;
        w_cnt_nxt   = 8'd0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  // Controls are forced quiet while reset is asserted, independent of the inputs.
  always_comb begin
    if (rst) begin
      w_out = w_dec;
    end else begin
      w_out = '0;
    end
  end

  assign bus.pc_hold       = w_out.pc_hold;
  assign bus.ifid_hold     = w_out.ifid_hold;
  assign bus.ifid_flush    = w_out.ifid_flush;
  assign bus.idex_hold     = w_out.idex_hold;
  assign bus.idex_flush    = w_out.idex_flush;
  assign bus.exls_hold     = w_out.exls_hold;
  assign bus.lswb_flush    = w_out.lswb_flush;
  assign bus.redirect_take = w_out.redirect_take;
  assign bus.mem_err       = w_out.mem_err;

  // FSM state, wait counter and deferred-redirect flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= YSYX_22051013_PCTL_RUN;
      r_cnt   <= 8'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

`ifdef YSYX_22051013_PIPE_PERF_EN
  // Event counters; free-running and wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_cnt    <= 32'd0;
      perf_mem_cnt   <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      perf_lu_cnt    <= perf_lu_cnt + {31'd0, w_lu_take};
      perf_mem_cnt   <= perf_mem_cnt + {31'd0, (r_state == YSYX_22051013_PCTL_MEMW)};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, w_out.redirect_take};
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22051013_pipe_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed control vectors, a negedge monitor pops and compares.
module tb_ysyx_22051013_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22051013_pipe_ctrl_if #(.REGADDR_W(5)) bus ();

`ifdef YSYX_22051013_PIPE_PERF_EN
  logic [31:0] perf_lu_cnt, perf_mem_cnt, perf_flush_cnt;
`endif

  ysyx_22051013_pipe_ctrl #(
    .REGADDR_W   (5),
    .MEM_TIMEOUT (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef YSYX_22051013_PIPE_PERF_EN
    ,
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_mem_cnt   (perf_mem_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exls_hold, lswb_flush, redirect_take, mem_err}
  localparam logic [8:0] E_NONE  = 9'b000000000;
  localparam logic [8:0] E_LU    = 9'b110010000;
  localparam logic [8:0] E_MEM   = 9'b110101100;
  localparam logic [8:0] E_REDIR = 9'b001010010;
  localparam logic [8:0] E_FETCH = 9'b101000000;
  localparam logic [8:0] E_ERR   = 9'b000000001;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  exp_t mon_e;
  logic [8:0] mon_got;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_got = {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_hold, bus.idex_flush,
                 bus.exls_hold, bus.lswb_flush, bus.redirect_take, bus.mem_err};
      checks++;
      if (mon_got !== mon_e.exp) begin
        failures++;
        $display("FAIL %s actual=%b required=%b", mon_e.name, mon_got, mon_e.exp);
      end
    end
  end

  task automatic push(input logic [8:0] e, input string n);
    exp_t t;
    t.exp  = e;
    t.name = n;
    q.push_back(t);
  endtask

  task automatic clr();
    bus.id_rs1_addr = 5'd0; bus.id_rs1_ren = 1'b0;
    bus.id_rs2_addr = 5'd0; bus.id_rs2_ren = 1'b0;
    bus.ex_rd_addr  = 5'd0; bus.ex_rd_ena  = 1'b0;
    bus.ex_is_load  = 1'b0; bus.ex_redirect = 1'b0;
    bus.if_req = 1'b0; bus.if_ack = 1'b0;
    bus.ls_req = 1'b0; bus.ls_ack = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic lu_hazard(input logic [4:0] rd, input logic [4:0] rs, input logic use_rs2);
    bus.ex_is_load = 1'b1;
    bus.ex_rd_ena  = 1'b1;
    bus.ex_rd_addr = rd;
    if (use_rs2) begin
      bus.id_rs2_addr = rs;
      bus.id_rs2_ren  = 1'b1;
    end else begin
      bus.id_rs1_addr = rs;
      bus.id_rs1_ren  = 1'b1;
    end
  endtask

  initial begin
    clr();
    // reset: busy inputs must not leak through
    nxt(); rst = 1'b0; bus.ls_req = 1'b1; bus.ex_redirect = 1'b1; lu_hazard(5'd5, 5'd5, 1'b0);
    push(E_NONE, "rst_active");
    nxt(); rst = 1'b1; push(E_NONE, "rst_release");

    // load-use
    nxt(); lu_hazard(5'd5, 5'd5, 1'b0); push(E_LU,   "lu_c0");
    nxt(); lu_hazard(5'd5, 5'd5, 1'b0); push(E_NONE, "lu_bubble");
    nxt(); lu_hazard(5'd0, 5'd0, 1'b0); push(E_NONE, "lu_x0");
    nxt(); lu_hazard(5'd7, 5'd7, 1'b1); push(E_LU,   "lu_rs2");
    nxt();                              push(E_NONE, "lu_rs2_bubble");
    nxt(); lu_hazard(5'd7, 5'd7, 1'b1); bus.id_rs2_ren = 1'b0; push(E_NONE, "lu_noren");
    nxt(); lu_hazard(5'd5, 5'd5, 1'b0); bus.ex_is_load = 1'b0; push(E_NONE, "lu_notload");
    nxt(); lu_hazard(5'd5, 5'd6, 1'b0); push(E_NONE, "lu_diffreg");

    // LSU ack on cycle 3 (same cycle the timeout would fire: ack wins)
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.ls_req = 1'b1; push(E_MEM, "lsu3_wait");
    end
    nxt(); bus.ls_req = 1'b1; bus.ls_ack = 1'b1; push(E_NONE, "lsu3_ack");
    nxt(); lu_hazard(5'd5, 5'd5, 1'b0); push(E_LU, "lsu3_run");
    nxt(); push(E_NONE, "lsu3_bubble");

    // ack with req: no stall
    nxt(); bus.ls_req = 1'b1; bus.ls_ack = 1'b1; push(E_NONE, "ls_ack_same");
    nxt(); bus.if_req = 1'b1; push(E_FETCH, "ls_ack_same_run");

    // timeout
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.ls_req = 1'b1; push(E_MEM, "tmo_wait");
    end
    nxt(); bus.ls_req = 1'b1; push(E_ERR, "tmo_err");
    nxt(); bus.if_req = 1'b1; push(E_FETCH, "tmo_run");

    // redirect during MEM_WAIT is deferred
    nxt(); bus.ls_req = 1'b1; push(E_MEM, "rmw_c0");
    nxt(); bus.ls_req = 1'b1; bus.ex_redirect = 1'b1; push(E_MEM, "rmw_c1");
    nxt(); bus.ls_req = 1'b1; bus.ls_ack = 1'b1; bus.ex_redirect = 1'b1; push(E_NONE, "rmw_ack");
    nxt(); push(E_REDIR, "rmw_pend");
    nxt(); bus.if_req = 1'b1; push(E_FETCH, "rmw_run");

    // redirect beats load-use, state stays RUN
    nxt(); lu_hazard(5'd5, 5'd5, 1'b0); bus.ex_redirect = 1'b1; push(E_REDIR, "redir_lu");
    nxt(); lu_hazard(5'd5, 5'd5, 1'b0); push(E_LU,   "redir_lu_run");
    nxt(); lu_hazard(5'd5, 5'd5, 1'b0); push(E_NONE, "redir_lu_bubble");

    // fetch wait
    nxt(); bus.if_req = 1'b1; push(E_FETCH, "fetch_wait");
    nxt(); bus.if_req = 1'b1; bus.if_ack = 1'b1; push(E_NONE, "fetch_ack");
    nxt(); bus.if_req = 1'b1; bus.ex_redirect = 1'b1; push(E_REDIR, "fetch_redir");

    // asynchronous reset mid-MEM_WAIT
    nxt(); bus.ls_req = 1'b1; push(E_MEM, "rmid_c0");
    nxt(); bus.ls_req = 1'b1; push(E_MEM, "rmid_c1");
    nxt(); bus.ls_req = 1'b1; rst = 1'b0; push(E_NONE, "rmid_rst");
`ifdef YSYX_22051013_PIPE_PERF_EN
    #1;
    checks++;
    if ({perf_lu_cnt, perf_mem_cnt, perf_flush_cnt} !== 96'd0) begin
      failures++;
      $display("FAIL perf_rst actual=%h/%h/%h required=0", perf_lu_cnt, perf_mem_cnt, perf_flush_cnt);
    end
`endif
    nxt(); rst = 1'b1; lu_hazard(5'd5, 5'd5, 1'b0); push(E_LU, "rmid_run");
    nxt(); push(E_NONE, "rmid_bubble");

    nxt();
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
